// File: rtl/char_buffer_ctrl.sv
// Character buffer for the text display path: random-access writes, a streaming
// put-char port with an auto-advancing cursor, a registered read port and a fill engine.
module char_buffer_ctrl #(
    parameter int                COLS      = 128,
    parameter int                ROWS      = 128,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 14,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20,
    parameter logic [DATA_W-1:0] NL_CHAR   = 8'h0A
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_req_i,
    output logic              busy_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              put_valid_i,
    output logic              put_ready_o,
    input  logic [DATA_W-1:0] put_char_i,
    output logic [ADDR_W-1:0] cursor_addr_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [ROW_W-1:0]    row_q, row_d, next_row;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   cursor_q, cursor_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                put_acc;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign busy_o        = rst_i | (state_q == FILL);
    assign put_ready_o   = (state_q == RUN) & ~wr_en_i & ~clear_req_i & ~rst_i;
    assign put_acc       = put_valid_i & put_ready_o;
    assign next_row      = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
    assign cursor_d      = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);
    assign cursor_addr_o = cursor_q;
    assign rd_data_o     = rd_data_q;

    // Exactly one RAM write source per cycle: fill, else clear (no write), else direct, else put.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        row_d       = row_q;
        col_d       = col_q;
        mem_we      = 1'b0;
        mem_waddr   = fill_addr_q;
        mem_wdata   = FILL_CHAR;
        case (state_q)
            FILL: begin
                mem_we = 1'b1;
                if (fill_addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    fill_addr_d = fill_addr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clear_req_i) begin
                    state_d     = FILL;
                    fill_addr_d = '0;
                    row_d       = '0;
                    col_d       = '0;
                end else if (wr_en_i) begin
                    mem_we    = ({1'b0, wr_addr_i} < DEPTH_X);
                    mem_waddr = wr_addr_i;
                    mem_wdata = wr_data_i;
                end else if (put_acc) begin
                    if (put_char_i == NL_CHAR) begin
                        col_d = '0;
                        row_d = next_row;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = cursor_q;
                        mem_wdata = put_char_i;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            fill_addr_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cursor_q    <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cursor_q    <= cursor_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    // Registered read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr_i} < DEPTH_X) begin
            rd_data_q <= mem[rd_addr_i[IDX_W-1:0]];
        end else begin
            rd_data_q <= FILL_CHAR;
        end
    end

endmodule
